// File: rtl/cc_game_pkg.sv
// Shared constants, encodings and the FSM state type for the candy-crush game engine.
package cc_game_pkg;
  localparam int BOARD_DIM = 6;
  localparam int CELLS = 36;
  localparam int N_ACTIONS = 10;
  localparam int N_STRIPE_LOADS = 4;
  localparam logic [2:0] EMPTY = 3'd0;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_DOWN  = 2'd1,
    ACT_LEFT  = 2'd2,
    ACT_RIGHT = 2'd3
  } action_e;

  typedef enum logic {
    STRIPE_H = 1'b0,
    STRIPE_V = 1'b1
  } stripe_e;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT_ACT, S_ACT, S_SWAP, S_MATCH, S_CLEAR, S_FALL, S_DONE
  } state_e;

  typedef struct packed {
    logic [5:0] pos;
    action_e    dir;
  } action_t;

  function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return 6'({3'b000, row} * 6'd6 + {3'b000, col});
  endfunction
endpackage

// File: rtl/cc_match.sv
// Combinational elimination marks: runs of three or more, then stripe chaining.
module cc_match
  import cc_game_pkg::*;
(
  input  logic [3*CELLS-1:0] color,
  input  logic [CELLS-1:0]   stripe_en,
  input  logic [CELLS-1:0]   stripe_type,
  output logic [CELLS-1:0]   mark
);
  // At most four stripes exist on a board, so five passes always reach the fixpoint.
  localparam int CHAIN_PASSES = N_STRIPE_LOADS + 1;

  logic [2:0]       c [CELLS];
  logic [CELLS-1:0] acc;
  logic [CELLS-1:0] nxt;

  always_comb begin
    for (int i = 0; i < CELLS; i++) c[i] = color[3*i +: 3];
  end

  always_comb begin
    acc = '0;
    nxt = '0;
    for (int r = 0; r < BOARD_DIM; r++) begin
      for (int k = 0; k <= BOARD_DIM - 3; k++) begin
        if (c[r*BOARD_DIM+k] != EMPTY && c[r*BOARD_DIM+k] == c[r*BOARD_DIM+k+1] &&
            c[r*BOARD_DIM+k] == c[r*BOARD_DIM+k+2])
          acc[r*BOARD_DIM+k +: 3] = 3'b111;
        if (c[k*BOARD_DIM+r] != EMPTY && c[k*BOARD_DIM+r] == c[(k+1)*BOARD_DIM+r] &&
            c[k*BOARD_DIM+r] == c[(k+2)*BOARD_DIM+r]) begin
          acc[k*BOARD_DIM+r]     = 1'b1;
          acc[(k+1)*BOARD_DIM+r] = 1'b1;
          acc[(k+2)*BOARD_DIM+r] = 1'b1;
        end
      end
    end
    for (int p = 0; p < CHAIN_PASSES; p++) begin
      nxt = acc;
      for (int i = 0; i < CELLS; i++) begin
        if (acc[i] && stripe_en[i]) begin
          for (int j = 0; j < CELLS; j++) begin
            if (c[j] != EMPTY &&
                ((stripe_type[i] == STRIPE_V) ? (j % BOARD_DIM == i % BOARD_DIM)
                                              : (j / BOARD_DIM == i / BOARD_DIM)))
              nxt[j] = 1'b1;
          end
        end
      end
      acc = nxt;
    end
    mark = acc;
  end
endmodule

// File: rtl/cc_game.sv
// Candy-crush engine: loads a 6x6 board, buffers ten swaps, then resolves
// matches, stripe blasts and gravity, reporting the total eliminated count.
module cc_game
  import cc_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_1,
  input  logic [2:0] in_color,
  input  logic [5:0] in_starting_pos,
  input  logic       in_stripe,
  input  logic       in_valid_2,
  input  logic [1:0] in_action,
  output logic       out_valid,
  output logic [6:0] out_score
);
  state_e           state_q, state_d;
  logic [2:0]       color_q [CELLS];
  logic [2:0]       color_d [CELLS];
  logic [CELLS-1:0] sten_q, sten_d, styp_q, styp_d;
  action_t          act_q [N_ACTIONS];
  action_t          act_d [N_ACTIONS];
  logic [5:0]       cnt_q, cnt_d;
  logic [3:0]       act_idx_q, act_idx_d;
  logic [6:0]       score_q, score_d;
  logic [CELLS-1:0] mark_q, mark_d, mark_c;
  logic [3*CELLS-1:0] color_flat;

  logic       act_start, s_ok, nb_ok, swap_ok;
  logic [5:0] s_idx, a_idx, n_idx, fall_src, fall_dst;
  logic [2:0] a_row, a_col, n_row, n_col, fall_w;
  action_t    cur;

  always_comb begin
    for (int i = 0; i < CELLS; i++) color_flat[3*i +: 3] = color_q[i];
  end

  cc_match u_match (
    .color       (color_flat),
    .stripe_en   (sten_q),
    .stripe_type (styp_q),
    .mark        (mark_c)
  );

  // Action 0 may arrive on the very cycle the board strobe drops.
  assign act_start = in_valid_2 &&
                     (state_q == S_WAIT_ACT || (state_q == S_LOAD && !in_valid_1));
  assign s_idx = cell_idx(in_starting_pos[5:3], in_starting_pos[2:0]);
  assign s_ok  = (in_starting_pos[5:3] < 3'(BOARD_DIM)) && (in_starting_pos[2:0] < 3'(BOARD_DIM));

  always_comb begin
    cur   = (act_idx_q < 4'(N_ACTIONS)) ? act_q[act_idx_q] : '0;
    a_row = cur.pos[5:3];
    a_col = cur.pos[2:0];
    n_row = a_row;
    n_col = a_col;
    nb_ok = (a_row < 3'(BOARD_DIM)) && (a_col < 3'(BOARD_DIM));
    case (cur.dir)
      ACT_UP:    begin nb_ok = nb_ok && (a_row != 3'd0);               n_row = a_row - 3'd1; end
      ACT_DOWN:  begin nb_ok = nb_ok && (a_row != 3'(BOARD_DIM - 1));  n_row = a_row + 3'd1; end
      ACT_LEFT:  begin nb_ok = nb_ok && (a_col != 3'd0);               n_col = a_col - 3'd1; end
      default:   begin nb_ok = nb_ok && (a_col != 3'(BOARD_DIM - 1));  n_col = a_col + 3'd1; end
    endcase
    a_idx   = cell_idx(a_row, a_col);
    n_idx   = cell_idx(n_row, n_col);
    swap_ok = nb_ok && (color_q[a_idx] != EMPTY) && (color_q[n_idx] != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (in_valid_1) state_d = S_LOAD;
      S_LOAD:     if (!in_valid_1) state_d = act_start ? S_ACT : S_WAIT_ACT;
      S_WAIT_ACT: if (act_start) state_d = S_ACT;
      S_ACT:      if (!in_valid_2) state_d = S_SWAP;
      S_SWAP:     state_d = (act_idx_q == 4'(N_ACTIONS)) ? S_DONE : S_MATCH;
      S_MATCH:    state_d = (|mark_c) ? S_CLEAR : S_SWAP;
      S_CLEAR:    state_d = S_FALL;
      S_FALL:     state_d = S_MATCH;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_score = '0;
    if (state_q == S_DONE) begin
      out_valid = 1'b1;
      out_score = score_q;
    end
  end

  always_comb begin
    color_d   = color_q;
    sten_d    = sten_q;
    styp_d    = styp_q;
    act_d     = act_q;
    cnt_d     = cnt_q;
    act_idx_d = act_idx_q;
    score_d   = score_q;
    mark_d    = mark_q;
    fall_w    = '0;
    fall_src  = '0;
    fall_dst  = '0;
    if (act_start) begin
      act_d[0]  = '{pos: in_starting_pos, dir: action_e'(in_action)};
      cnt_d     = 6'd1;
      act_idx_d = '0;
    end
    case (state_q)
      S_IDLE: if (in_valid_1) begin
        color_d[0] = in_color;
        sten_d     = '0;
        styp_d     = '0;
        if (s_ok) begin
          sten_d[s_idx] = 1'b1;
          styp_d[s_idx] = in_stripe;
        end
        cnt_d   = 6'd1;
        score_d = '0;
      end
      S_LOAD: if (in_valid_1 && cnt_q < 6'(CELLS)) begin
        color_d[cnt_q] = in_color;
        if (cnt_q < 6'(N_STRIPE_LOADS) && s_ok) begin
          sten_d[s_idx] = 1'b1;
          styp_d[s_idx] = in_stripe;
        end
        cnt_d = cnt_q + 6'd1;
      end
      S_ACT: if (in_valid_2 && cnt_q < 6'(N_ACTIONS)) begin
        act_d[cnt_q[3:0]] = '{pos: in_starting_pos, dir: action_e'(in_action)};
        cnt_d = cnt_q + 6'd1;
      end
      S_SWAP: if (act_idx_q < 4'(N_ACTIONS)) begin
        if (swap_ok) begin
          color_d[a_idx] = color_q[n_idx];
          color_d[n_idx] = color_q[a_idx];
          sten_d[a_idx]  = sten_q[n_idx];
          sten_d[n_idx]  = sten_q[a_idx];
          styp_d[a_idx]  = styp_q[n_idx];
          styp_d[n_idx]  = styp_q[a_idx];
        end
        act_idx_d = act_idx_q + 4'd1;
      end
      S_MATCH: mark_d = mark_c;
      S_CLEAR: begin
        score_d = score_q + 7'($countones(mark_q));
        for (int i = 0; i < CELLS; i++) begin
          if (mark_q[i]) begin
            color_d[i] = EMPTY;
            sten_d[i]  = 1'b0;
            styp_d[i]  = 1'b0;
          end
        end
      end
      S_FALL: begin
        for (int c = 0; c < BOARD_DIM; c++) begin
          for (int r = 0; r < BOARD_DIM; r++) begin
            fall_dst          = cell_idx(3'(r), 3'(c));
            color_d[fall_dst] = EMPTY;
            sten_d[fall_dst]  = 1'b0;
            styp_d[fall_dst]  = 1'b0;
          end
          fall_w = 3'(BOARD_DIM - 1);
          for (int r = BOARD_DIM - 1; r >= 0; r--) begin
            fall_src = cell_idx(3'(r), 3'(c));
            if (color_q[fall_src] != EMPTY) begin
              fall_dst          = cell_idx(fall_w, 3'(c));
              color_d[fall_dst] = color_q[fall_src];
              sten_d[fall_dst]  = sten_q[fall_src];
              styp_d[fall_dst]  = styp_q[fall_src];
              fall_w            = fall_w - 3'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      color_q   <= '{default: EMPTY};
      sten_q    <= '0;
      styp_q    <= '0;
      act_q     <= '{default: '0};
      cnt_q     <= '0;
      act_idx_q <= '0;
      score_q   <= '0;
      mark_q    <= '0;
    end else begin
      color_q   <= color_d;
      sten_q    <= sten_d;
      styp_q    <= styp_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      act_idx_q <= act_idx_d;
      score_q   <= score_d;
      mark_q    <= mark_d;
    end
  end
endmodule

// File: tb/tb_cc_game.sv
// Directed bench for cc_game: hand-built boards with hand-computed scores.
module tb_cc_game;
  logic       clk;
  logic       rst_n;
  logic       in_valid_1;
  logic [2:0] in_color;
  logic [5:0] in_starting_pos;
  logic       in_stripe;
  logic       in_valid_2;
  logic [1:0] in_action;
  logic       out_valid;
  logic [6:0] out_score;

  int total = 0;
  int bad = 0;

  logic [2:0] board [36];
  logic [5:0] spos [4];
  logic       stype [4];
  logic [5:0] apos [10];
  logic [1:0] adir [10];

  cc_game dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_1      (in_valid_1),
    .in_color        (in_color),
    .in_starting_pos (in_starting_pos),
    .in_stripe       (in_stripe),
    .in_valid_2      (in_valid_2),
    .in_action       (in_action),
    .out_valid       (out_valid),
    .out_score       (out_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rows use 3+((r+2c)%5): neighbours always differ, so no runs anywhere.
  task automatic base_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        board[r*6+c] = 3'(3 + (r + 2*c) % 5);
  endtask

  task automatic row5_special();
    board[30] = 3'd1; board[31] = 3'd1; board[32] = 3'd2;
    board[33] = 3'd1; board[34] = 3'd3; board[35] = 3'd5;
  endtask

  task automatic stripes_far();
    for (int i = 0; i < 4; i++) begin
      spos[i]  = {3'd0, 3'd5};
      stype[i] = 1'b0;
    end
  endtask

  task automatic actions_off();
    for (int i = 0; i < 10; i++) begin
      apos[i] = (i % 2 == 0) ? {3'd0, 3'd0} : {3'd0, 3'd5};
      adir[i] = (i % 2 == 0) ? 2'd0 : 2'd3;
    end
  endtask

  task automatic cascade_board();
    base_board();
    board[12] = 3'd2; board[18] = 3'd1; board[24] = 3'd2; board[30] = 3'd2;
    board[19] = 3'd1; board[21] = 3'd1;
  endtask

  task automatic load_board();
    for (int i = 0; i < 36; i++) begin
      in_valid_1 = 1'b1;
      in_color   = board[i];
      if (i < 4) begin
        in_starting_pos = spos[i];
        in_stripe       = stype[i];
      end else begin
        in_starting_pos = 6'($urandom);
        in_stripe       = 1'($urandom);
      end
      tick();
    end
    in_valid_1 = 1'b0;
    in_color   = 3'd0;
  endtask

  task automatic send_actions();
    for (int i = 0; i < 10; i++) begin
      in_valid_2      = 1'b1;
      in_starting_pos = apos[i];
      in_action       = adir[i];
      tick();
    end
    in_valid_2      = 1'b0;
    in_action       = 2'($urandom);
    in_starting_pos = 6'($urandom);
  endtask

  task automatic wait_result(input string tag, input int exp);
    int   cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 500) begin
      @(negedge clk);
      cyc++;
      seen = out_valid;
    end
    chk({tag, "_valid"}, 32'(seen), 32'd1);
    if (seen) chk({tag, "_score"}, 32'(out_score), 32'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    chk({tag, "_score_idle"}, 32'(out_score), 32'd0);
  endtask

  task automatic play(input string tag, input int exp);
    tick();
    load_board();
    repeat (3) tick();
    send_actions();
    wait_result(tag, exp);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b1; in_valid_1 = 1'b0; in_color = 3'd0; in_starting_pos = 6'd0;
    in_stripe = 1'b0; in_valid_2 = 1'b0; in_action = 2'd0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_score", 32'(out_score), 32'd0);
    tick();
    rst_n = 1'b0;

    // Action strobe while idle must be ignored.
    actions_off();
    apos[0] = {3'd5, 3'd2}; adir[0] = 2'd3;
    send_actions();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("idle_strobe_ignored", 32'(pulses), 32'd0);

    // Row-5 triple via swap, stripes parked far away: 3.
    base_board(); row5_special(); stripes_far(); actions_off();
    apos[0] = {3'd5, 3'd2}; adir[0] = 2'd3;
    play("triple", 3);

    // Same with a horizontal stripe inside the triple: whole row, 6.
    stype[0] = 1'b0; spos[0] = {3'd5, 3'd1};
    play("stripe_row", 6);

    // Only off-board actions: 0.
    base_board(); row5_special(); stripes_far(); actions_off();
    play("offboard", 0);

    // Row-3 triple then a falling vertical triple in column 0: 6.
    cascade_board(); stripes_far(); actions_off();
    apos[0] = {3'd3, 3'd2}; adir[0] = 2'd3;
    play("cascade", 6);

    // Reset during resolve aborts the game.
    tick();
    load_board();
    repeat (3) tick();
    send_actions();
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_score", 32'(out_score), 32'd0);
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("midreset_no_pulse", 32'(pulses), 32'd0);

    base_board(); row5_special(); stripes_far(); actions_off();
    apos[0] = {3'd5, 3'd2}; adir[0] = 2'd3;
    spos[0] = {3'd5, 3'd1}; stype[0] = 1'b0;
    play("after_reset", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cc_game.md
CC_GAME -- requirements
Module: cc_game

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; all state changes on this edge.
REQ-002 SHALL have port: rst_n  in  1  reset; synchronous, active-high (asserted when 1) despite its name.
REQ-003 SHALL have port: in_valid_1  in  1  board-load strobe, high exactly 36 consecutive cycles.
REQ-004 SHALL have port: in_color  in  3  candy colour 1..7 for the current cell, row-major, cell 0 first.
REQ-005 SHALL have port: in_starting_pos  in  6  [5:3]=row, [2:0]=col; stripe position in load cycles 0..3, action position while in_valid_2=1.
REQ-006 SHALL have port: in_stripe  in  1  stripe type in load cycles 0..3: 0=horizontal (clears row), 1=vertical (clears column).
REQ-007 SHALL have port: in_valid_2  in  1  action strobe, high exactly 10 consecutive cycles.
REQ-008 SHALL have port: in_action  in  2  swap direction: 0=up (row-1), 1=down (row+1), 2=left (col-1), 3=right (col+1).
REQ-009 SHALL have port: out_valid  out  1  one-cycle result pulse.
REQ-010 SHALL have port: out_score  out  7  total candies eliminated over the 10 actions; 0 whenever out_valid=0.

Function
REQ-011 Board SHALL be 6x6; row 0 top, row 5 bottom; cell i is row i/6, col i%6; colour 0 means empty and is never accepted as input.
REQ-012 In load cycles 0..3 the cell at in_starting_pos SHALL be marked striped with type in_stripe; it may precede its colour arriving; duplicate positions: last one wins.
REQ-013 Inputs marked don't-care (in_starting_pos/in_stripe after load cycle 3, in_action outside in_valid_2) SHALL be ignored.
REQ-014 All 10 actions SHALL be buffered, then processed in arrival order after in_valid_2 falls.
REQ-015 An action SHALL swap colour and stripe of the cell with its neighbour in the given direction; off-board neighbour or either cell empty -> no-op.
REQ-016 A swap producing no elimination SHALL remain in place (no revert).
REQ-017 After each swap, resolve loop: mark every cell in a horizontal or vertical run of >=3 equal non-empty colours.
REQ-018 A marked striped cell SHALL additionally mark every non-empty cell in its row (type 0) or column (type 1); newly marked stripes chain until no new marks.
REQ-019 Score SHALL add the number of marked cells; marked cells become empty and lose stripe status.
REQ-020 Gravity: per column, remaining candies fall to the lowest empty rows keeping order and stripes; no refill.
REQ-021 Resolve loop SHALL repeat until a pass marks nothing, then next action starts.
REQ-022 Score counter 7 bits, cleared at start of each board load; max possible 36, no overflow handling needed.
REQ-023 out_valid SHALL pulse exactly one cycle, at most 500 cycles after in_valid_2 falls, then module returns to idle ready for the next board with no further reset.
REQ-024 FSM states: IDLE -> LOAD (in_valid_1) -> WAIT_ACT -> ACT (in_valid_2) -> SWAP -> MATCH -> CLEAR -> FALL -> (MATCH | SWAP | DONE) -> IDLE.
REQ-025 Strobes arriving in wrong state SHALL be ignored.

Reset
REQ-026 While rst_n=1 on a clk edge: out_valid=0, out_score=0, FSM=IDLE, board, stripes, action buffer, score cleared.
REQ-027 Reset mid-operation SHALL abort the game; no out_valid until a full new load and action sequence.

Structure
REQ-028 Package cc_game_pkg SHALL hold BOARD_DIM=6, CELLS=36, N_ACTIONS=10, EMPTY=0, action encodings, stripe encodings, FSM state enum.
REQ-029 One sub-module cc_match SHALL combinationally produce the 36-bit mark vector (runs plus stripe chaining) from board colours and stripes.

Verification
REQ-030 No stripes hit, board alternating colours with row 5 = 1,1,2,1,1,1 (rest distinct, no runs); action (5,2) right -> row becomes 1,1,1,2,1,1 -> score 3, out_valid one cycle.
REQ-031 Same as REQ-030 with horizontal stripe at (5,1) -> row 5 fully cleared -> score 6.
REQ-032 Action at (0,0) up and (0,5) right (off-board) for all 10 actions, no initial runs -> out_score=0 with out_valid pulse.
REQ-033 Cascade: clearing a row-3 triple causes a fall forming a vertical triple -> score 6.
REQ-034 rst_n asserted mid-resolve -> out_valid=0, out_score=0; subsequent full game scores correctly; out_valid high <=500 cycles after in_valid_2 falls in all tests.
